secded72_decoder_pipe: RTL and testbench

- Two-stage pipelined SEC-DED decoder for 72-bit codewords (64 data + 8 check), directly downstream of the fault-injection stage.
- Consumes the possibly corrupted codeword, corrects single-bit errors and flags double errors.
- Provides valid/ready flow control and saturating error counters for fault-campaign statistics.

---
 rtl/secded72_decoder_pipe.sv | 178 +++++++++++++++++
 tb/tb_secded72_decoder_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/secded72_decoder_pipe.sv
// rtl/secded72_decoder_pipe.sv - two-stage SEC-DED (72,64) decoder with valid/ready flow control and saturating error counters
// Optional error-position log enabled by defining SECDED72_ERR_LOG_EN.
module secded72_decoder_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [71:0]      in_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_corr,
    output logic             out_uncorr,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
`ifdef SECDED72_ERR_LOG_EN
    ,
    output logic             err_log_valid,
    output logic [6:0]       err_log_pos
`endif
);

    function automatic logic [6:0] calc_syn(input logic [71:0] cw);
        logic [6:0] s;
        s = '0;
        for (int i = 1; i < 72; i++) begin
            for (int k = 0; k < 7; k++) begin
                if (i[k]) s[k] = s[k] ^ cw[i];
            end
        end
        return s;
    endfunction

    // Data bits occupy every non-power-of-two index above 0, in ascending order.
    function automatic logic [63:0] extract_data(input logic [71:0] cw);
        logic [63:0] d;
        int          j;
        d = '0;
        j = 0;
        for (int i = 1; i < 72; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j[5:0]] = cw[i];
                j++;
            end
        end
        return d;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [71:0]      s1_cw_q, s1_cw_d;
    logic [6:0]       s1_syn_q, s1_syn_d;
    logic             s1_par_q, s1_par_d;
    logic             out_valid_q, out_valid_d;
    logic [63:0]      out_data_q, out_data_d;
    logic             out_corr_q, out_corr_d;
    logic             out_uncorr_q, out_uncorr_d;
    logic [6:0]       out_syn_q, out_syn_d;
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;
    logic             log_valid_q, log_valid_d;
    logic [6:0]       log_pos_q, log_pos_d;

    logic        s2_en, s1_adv, s1_load, out_xfer;
    logic        single_err, multi_err;
    logic [71:0] fixed_cw;

    always_comb begin
        s2_en      = !out_valid_q || out_ready;
        s1_adv     = s1_valid_q && s2_en;
        in_ready   = !s1_valid_q || s1_adv;
        s1_load    = in_valid && in_ready;
        out_xfer   = out_valid_q && out_ready;

        single_err = s1_par_q && (s1_syn_q <= 7'd71);
        multi_err  = (!s1_par_q && (s1_syn_q != 7'd0)) || (s1_par_q && (s1_syn_q > 7'd71));
        fixed_cw   = s1_cw_q ^ (single_err ? (72'd1 << s1_syn_q) : 72'd0);

        s1_valid_d = s1_valid_q;
        s1_cw_d    = s1_cw_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_cw_d    = in_cw;
            s1_syn_d   = calc_syn(in_cw);
            s1_par_d   = ^in_cw;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_corr_d   = out_corr_q;
        out_uncorr_d = out_uncorr_q;
        out_syn_d    = out_syn_q;
        if (s1_adv) begin
            out_valid_d  = 1'b1;
            out_data_d   = extract_data(fixed_cw);
            out_corr_d   = single_err;
            out_uncorr_d = multi_err;
            out_syn_d    = s1_syn_q;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        // Clear wins over a same-cycle event, which is deliberately not counted.
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        log_valid_d  = log_valid_q;
        log_pos_d    = log_pos_q;
        if (cnt_clr) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
            log_valid_d  = 1'b0;
            log_pos_d    = '0;
        end else if (out_xfer) begin
            if (out_corr_q && (corr_cnt_q != {CNT_W{1'b1}}))
                corr_cnt_d = corr_cnt_q + 1'b1;
            if (out_uncorr_q && (uncorr_cnt_q != {CNT_W{1'b1}}))
                uncorr_cnt_d = uncorr_cnt_q + 1'b1;
            if ((out_corr_q || out_uncorr_q) && !log_valid_q) begin
                log_valid_d = 1'b1;
                log_pos_d   = out_syn_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_cw_q      <= '0;
            s1_syn_q     <= '0;
            s1_par_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
            out_syn_q    <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
            log_valid_q  <= 1'b0;
            log_pos_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_cw_q      <= s1_cw_d;
            s1_syn_q     <= s1_syn_d;
            s1_par_q     <= s1_par_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_corr_q   <= out_corr_d;
            out_uncorr_q <= out_uncorr_d;
            out_syn_q    <= out_syn_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
            log_valid_q  <= log_valid_d;
            log_pos_q    <= log_pos_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_corr   = out_corr_q;
    assign out_uncorr = out_uncorr_q;
    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;

`ifdef SECDED72_ERR_LOG_EN
    assign err_log_valid = log_valid_q;
    assign err_log_pos   = log_pos_q;
`else
    logic unused_log;
    assign unused_log = log_valid_q ^ (^log_pos_q);
`endif

endmodule

// File: tb/tb_secded72_decoder_pipe.sv
// tb/tb_secded72_decoder_pipe.sv - directed-vector self-checking bench for secded72_decoder_pipe
module tb_secded72_decoder_pipe;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [71:0]      in_cw;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic             out_corr;
    logic             out_uncorr;
    logic             cnt_clr;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;
`ifdef SECDED72_ERR_LOG_EN
    logic             err_log_valid;
    logic [6:0]       err_log_pos;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    secded72_decoder_pipe #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cw      (in_cw),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_corr   (out_corr),
        .out_uncorr (out_uncorr),
        .cnt_clr    (cnt_clr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
`ifdef SECDED72_ERR_LOG_EN
        ,
        .err_log_valid (err_log_valid),
        .err_log_pos   (err_log_pos)
`endif
    );

    // Drives one codeword with out_ready high and captures the decoded result.
    task automatic send_one(input logic [71:0] cw, output logic [63:0] d,
                            output logic c, output logic u, output logic ok);
        int n;
        in_cw = cw; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        ok = out_valid; d = out_data; c = out_corr; u = out_uncorr;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_cw = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_vec++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_vec++; if ({out_corr, out_uncorr} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {out_corr, out_uncorr}); end
        n_vec++; if (corr_cnt !== 4'h0 || uncorr_cnt !== 4'h0) begin n_fail++; $display("FAIL reset_cnts: got %h/%h want 0/0", corr_cnt, uncorr_cnt); end
`ifdef SECDED72_ERR_LOG_EN
        n_vec++; if (err_log_valid !== 1'b0 || err_log_pos !== 7'd0) begin n_fail++; $display("FAIL reset_log: got %b/%0d want 0/0", err_log_valid, err_log_pos); end
`endif
    endtask

    task automatic test_clean;
        in_cw = 72'h0; in_valid = 1'b1; out_ready = 1'b1;
        n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clean_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clean_lat1: got %b want 0", out_valid); end
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clean_lat2: got %b want 1", out_valid); end
        n_vec++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL clean_data: got %h want 0", out_data); end
        n_vec++; if ({out_corr, out_uncorr} !== 2'b00) begin n_fail++; $display("FAIL clean_flags: got %b want 00", {out_corr, out_uncorr}); end
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clean_drain: got %b want 0", out_valid); end
        n_vec++; if (corr_cnt !== 4'h0 || uncorr_cnt !== 4'h0) begin n_fail++; $display("FAIL clean_cnts: got %h/%h want 0/0", corr_cnt, uncorr_cnt); end
    endtask

    task automatic test_parity;
        logic [63:0] d; logic c, u, ok;
        send_one(72'h1, d, c, u, ok);
        n_vec++; if (ok !== 1'b1) begin n_fail++; $display("FAIL parity_timeout: got %b want 1", ok); end
        n_vec++; if (d !== 64'h0) begin n_fail++; $display("FAIL parity_data: got %h want 0", d); end
        n_vec++; if ({c, u} !== 2'b10) begin n_fail++; $display("FAIL parity_flags: got %b want 10", {c, u}); end
        n_vec++; if (corr_cnt !== 4'h1) begin n_fail++; $display("FAIL parity_cnt: got %h want 1", corr_cnt); end
`ifdef SECDED72_ERR_LOG_EN
        n_vec++; if (err_log_valid !== 1'b1 || err_log_pos !== 7'd0) begin n_fail++; $display("FAIL parity_log: got %b/%0d want 1/0", err_log_valid, err_log_pos); end
`endif
    endtask

    task automatic test_single;
        logic [71:0] cw  [5];
        logic [63:0] exd [5];
        logic        exc [5];
        logic [63:0] d; logic c, u, ok;
        cw[0] = 72'h00_0000_0000_0000_000F; exd[0] = 64'h1; exc[0] = 1'b0;
        cw[1] = 72'h00_0000_0000_0000_002F; exd[1] = 64'h1; exc[1] = 1'b1;
        cw[2] = 72'h00_0000_0000_0000_0007; exd[2] = 64'h1; exc[2] = 1'b1;
        cw[3] = 72'h81_0000_0000_0000_0017; exd[3] = 64'h8000_0000_0000_0000; exc[3] = 1'b0;
        cw[4] = 72'h80_0000_0000_0000_0017; exd[4] = 64'h8000_0000_0000_0000; exc[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_one(cw[i], d, c, u, ok);
            n_vec++; if (ok !== 1'b1 || d !== exd[i]) begin n_fail++; $display("FAIL single_data[%0d]: got %h ok=%b want %h", i, d, ok, exd[i]); end
            n_vec++; if ({c, u} !== {exc[i], 1'b0}) begin n_fail++; $display("FAIL single_flags[%0d]: got %b want %b0", i, {c, u}, exc[i]); end
        end
        n_vec++; if (corr_cnt !== 4'h4) begin n_fail++; $display("FAIL single_cnt: got %h want 4", corr_cnt); end
`ifdef SECDED72_ERR_LOG_EN
        n_vec++; if (err_log_valid !== 1'b1 || err_log_pos !== 7'd0) begin n_fail++; $display("FAIL single_log_hold: got %b/%0d want 1/0", err_log_valid, err_log_pos); end
`endif
    endtask

    task automatic test_double;
        logic [63:0] d; logic c, u, ok;
        send_one(72'h00_0000_0100_0000_0008, d, c, u, ok);
        n_vec++; if (ok !== 1'b1 || d !== 64'h0000_0002_0000_0001) begin n_fail++; $display("FAIL double_data: got %h ok=%b want 0000000200000001", d, ok); end
        n_vec++; if ({c, u} !== 2'b01) begin n_fail++; $display("FAIL double_flags: got %b want 01", {c, u}); end
        n_vec++; if (uncorr_cnt !== 4'h1) begin n_fail++; $display("FAIL double_cnt: got %h want 1", uncorr_cnt); end
        send_one(72'h01_0000_0000_0000_0101, d, c, u, ok);
        n_vec++; if (ok !== 1'b1 || d !== 64'h0) begin n_fail++; $display("FAIL synbig_data: got %h ok=%b want 0", d, ok); end
        n_vec++; if ({c, u} !== 2'b01) begin n_fail++; $display("FAIL synbig_flags: got %b want 01", {c, u}); end
        n_vec++; if (uncorr_cnt !== 4'h2 || corr_cnt !== 4'h4) begin n_fail++; $display("FAIL synbig_cnts: got %h/%h want 4/2", corr_cnt, uncorr_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [71:0] b_cw [8];
        logic [63:0] b_d  [8];
        logic [1:0]  b_f  [8];
        int k, got, cyc;
        logic acc;
        b_cw[0] = 72'h0;                        b_d[0] = 64'h0;                   b_f[0] = 2'b00;
        b_cw[1] = 72'hF;                        b_d[1] = 64'h1;                   b_f[1] = 2'b00;
        b_cw[2] = 72'h2F;                       b_d[2] = 64'h1;                   b_f[2] = 2'b10;
        b_cw[3] = 72'h81_0000_0000_0000_0017;   b_d[3] = 64'h8000_0000_0000_0000; b_f[3] = 2'b00;
        b_cw[4] = 72'h80_0000_0000_0000_0017;   b_d[4] = 64'h8000_0000_0000_0000; b_f[4] = 2'b10;
        b_cw[5] = 72'h1;                        b_d[5] = 64'h0;                   b_f[5] = 2'b10;
        b_cw[6] = 72'h00_0000_0100_0000_0008;   b_d[6] = 64'h0000_0002_0000_0001; b_f[6] = 2'b01;
        b_cw[7] = 72'h7;                        b_d[7] = 64'h1;                   b_f[7] = 2'b10;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        k = 0; got = 0; cyc = 0;
        while (got < 8 && cyc < 60) begin
            out_ready = (cyc >= 5);
            if (k < 8) begin in_valid = 1'b1; in_cw = b_cw[k]; end
            else in_valid = 1'b0;
            #1;
            if (cyc == 4) begin
                n_vec++; if (k != 2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_accept: got k=%0d in_ready=%b want 2/0", k, in_ready); end
            end
            acc = in_valid && in_ready;
            if (out_valid) begin
                n_vec++; if (out_data !== b_d[got] || {out_corr, out_uncorr} !== b_f[got]) begin
                    n_fail++; $display("FAIL b2b_out[%0d]: got %h/%b want %h/%b", got, out_data, {out_corr, out_uncorr}, b_d[got], b_f[got]);
                end
                if (out_ready) got++;
            end
            @(posedge clk); #1;
            if (acc) k++;
            cyc++;
        end
        in_valid = 1'b0;
        n_vec++; if (got != 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", got); end
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup: got %b want 0", out_valid); end
        n_vec++; if (corr_cnt !== 4'h4 || uncorr_cnt !== 4'h1) begin n_fail++; $display("FAIL b2b_cnts: got %h/%h want 4/1", corr_cnt, uncorr_cnt); end
    endtask

    task automatic test_saturate;
        in_cw = 72'h1; in_valid = 1'b1; out_ready = 1'b1;
        repeat ((1 << CNT_W) + 3) @(posedge clk);
        #1; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (corr_cnt !== {CNT_W{1'b1}}) begin n_fail++; $display("FAIL sat_corr: got %h want f", corr_cnt); end
        n_vec++; if (uncorr_cnt !== 4'h1) begin n_fail++; $display("FAIL sat_uncorr: got %h want 1", uncorr_cnt); end
    endtask

    task automatic test_clr_same_cycle;
        logic [63:0] d; logic c, u, ok;
        send_one(72'h00_0000_0100_0000_0008, d, c, u, ok);
        n_vec++; if (uncorr_cnt !== 4'h2) begin n_fail++; $display("FAIL clr_pre: got %h want 2", uncorr_cnt); end
        out_ready = 1'b0; in_cw = 72'h00_0000_0100_0000_0008; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b1 || out_uncorr !== 1'b1) begin n_fail++; $display("FAIL clr_held: got %b/%b want 1/1", out_valid, out_uncorr); end
        out_ready = 1'b1; cnt_clr = 1'b1;
        @(posedge clk); #1; cnt_clr = 1'b0;
        n_vec++; if (uncorr_cnt !== 4'h0 || corr_cnt !== 4'h0) begin n_fail++; $display("FAIL clr_cnts: got %h/%h want 0/0", corr_cnt, uncorr_cnt); end
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_xfer: got %b want 0", out_valid); end
`ifdef SECDED72_ERR_LOG_EN
        n_vec++; if (err_log_valid !== 1'b0 || err_log_pos !== 7'd0) begin n_fail++; $display("FAIL clr_log: got %b/%0d want 0/0", err_log_valid, err_log_pos); end
`endif
    endtask

    task automatic test_reset_inflight;
        int seen;
        out_ready = 1'b0; in_cw = 72'h2F; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1; in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstfl_loaded: got %b want 1", out_valid); end
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstfl_out_valid: got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstfl_in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1; seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_vec++; if (seen != 0) begin n_fail++; $display("FAIL rstfl_delivered: got %0d want 0", seen); end
        n_vec++; if (corr_cnt !== 4'h0) begin n_fail++; $display("FAIL rstfl_cnt: got %h want 0", corr_cnt); end
    endtask

    initial begin
        test_reset;
        test_clean;
        test_parity;
        test_single;
        test_double;
        test_back_to_back;
        test_saturate;
        test_clr_same_cycle;
        test_reset_inflight;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
